ddr3_init_cmd_responder: RTL
============================

// Module: ddr3_init_cmd_responder
// PURPOSE
//  DRAM-side receiver for the DDR3 command bus driven by the PHY during power-up initialization.
//  Samples cke/cs_n/ras_n/cas_n/we_n/ba/addr each clk, decodes the command and checks it against
//  the JEDEC init order (CKE up, tXPR, MR2, MR3, MR1, MR0, tMOD, ZQCL, tZQinit).
//  Captures mode-register values and raises init_done or a sticky error code; sits beside the DRAM model.
// PARAMETERS
//  BA_BITS    3    bank address width
//  ADDR_BITS  14   row/col address width (>=11)
//  T_XPR      170  min clk cycles from CKE rise to first MRS
//  T_MRD      4    min clk cycles between consecutive MRS
//  T_MOD      12   min clk cycles from MR0 MRS to ZQCL
//  T_ZQINIT   512  clk cycles from ZQCL until init_done
// PORTS
//  clk        in   1          command-bus sample clock (rising edge)
//  rst        in   1          asynchronous, active-high reset
//  cke        in   1          clock enable from PHY
//  cs_n       in   1          chip select, active low
//  ras_n      in   1          row address strobe
//  cas_n      in   1          column address strobe
//  we_n       in   1          write enable
//  ba         in   BA_BITS    bank address; MRS selects MR index via ba[1:0]
//  addr       in   ADDR_BITS  address / MRS payload; addr[10]=1 marks ZQCL
//  cmd_valid  out  1          1-cycle pulse: a non-NOP/non-DES command was decoded
//  cmd_code   out  3          decoded cmd: 0 MRS,1 REF,2 PRE,3 ACT,4 WR,5 RD,6 ZQ,7 NOP/DES
//  mr0..mr3   out  ADDR_BITS  last captured payload of MR0..MR3
//  init_done  out  1          high after full sequence + T_ZQINIT; holds until rst
//  init_err   out  1          sticky error flag
//  err_code   out  3          first error cause (0 none), frozen after first error
// BEHAVIOUR
//  - Reset: all outputs 0, cmd_code=7, FSM=WAIT_CKE, gap counter=0. Async assert, sync release.
//  - Decode: cs_n=1 -> DES(7); else {ras_n,cas_n,we_n}: 000 MRS,001 REF,010 PRE,011 ACT,
//    100 WR,101 RD,110 ZQ,111 NOP. cmd_code/cmd_valid registered: 1-cycle latency after sample edge.
//  - Gap counter: cleared when FSM enters a state; +1 per cycle, saturates at all-ones
//    (width $clog2(max(T_XPR,T_ZQINIT))+1).
//  - FSM:
//    WAIT_CKE: cke=1 -> WAIT_XPR. Any command != NOP/DES here -> err 4.
//    WAIT_XPR: MRS with cnt>=T_XPR-1 -> MRS order check; MRS earlier -> err 1.
//    MR2->MR3->MR1->MR0: each state expects MRS with ba[1:0]=2,3,1,0 resp.; each MRS needs
//      cnt>=T_MRD-1 since previous MRS, else err 1. Wrong ba -> err 2. Payload latched to mrN.
//    WAIT_MOD: after MR0; ZQ with addr[10]=1 and cnt>=T_MOD-1 -> WAIT_ZQ; early -> err 1;
//      ZQ with addr[10]=0 (ZQCS) -> err 2.
//    WAIT_ZQ: any command != NOP/DES -> err 1; cnt==T_ZQINIT-1 -> DONE, init_done=1 next edge.
//    DONE: decoder keeps reporting cmd_valid/cmd_code; no further order checking; MRS still updates mrN.
//    ERR: terminal until rst; init_err=1, init_done=0, decode continues.
//  - In any state except WAIT_CKE: cke=0 -> err 3 (takes priority over other checks same cycle).
//  - In WAIT_XPR..WAIT_MOD, non-MRS/non-ZQ commands (REF/PRE/ACT/RD/WR) -> err 4;
//    PRE before MR2 is tolerated (JEDEC PREA allowed).
//  - Simultaneous causes: lowest-numbered err_code wins except err 3 first. Only first error latched.
//  - rst mid-sequence: immediately returns to WAIT_CKE, mrN cleared.
// CONFIGURATION
//  INIT_MR_CHECK_EN defined: on MR0 capture, BL field addr[1:0]!=2'b00 (BL8 fixed) or
//    CL field {addr[6:4],addr[2]}==0 -> err 5; on MR1 capture, addr[0]=1 (DLL disable) -> err 5.
//  Not defined: payloads captured without content checks; err 5 never produced.
// TESTING
//  T1 legal sequence: rst 3 cyc, cke=1, 170 NOP, MRS ba=2/3/1/0 spaced 4 cyc, 12 NOP, ZQ addr[10]=1,
//     512 NOP -> init_done=1 exactly T_ZQINIT cycles after ZQ edge, err_code=0, mr0..3 = driven payloads.
//  T2 MRS at cycle 100 after cke rise -> init_err=1, err_code=1, init_done stays 0.
//  T3 MRS order ba=2 then ba=1 -> err_code=2; later legal commands do not change err_code.
//  T4 cke dropped to 0 during WAIT_ZQ -> err_code=3 one cycle later; rst then legal T1 replay -> init_done=1.
//  T5 decoder sweep in DONE: drive ACT,RD,WR,PRE,REF,DES -> cmd_code 3,5,4,2,1,7; cmd_valid only for first five.
//  T6 (INIT_MR_CHECK_EN) MR0 payload addr[1:0]=2'b10 -> err_code=5; without macro same stimulus -> no error.

Source files
------------

// File: rtl/ddr3_init_cmd_responder_if.sv
// ddr3_init_cmd_responder_if
//   DDR3 command bus as driven by the PHY during power-up initialization.
//   master : PHY side (drives every signal)
//   slave  : DRAM-side responder (samples every signal)
//   Signals: cke, cs_n, ras_n, cas_n, we_n, ba[BA_BITS], addr[ADDR_BITS]
interface ddr3_init_cmd_responder_if #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14
);
    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] addr;

    modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr);
    modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr);
endinterface

// File: rtl/ddr3_init_cmd_responder.sv
// ddr3_init_cmd_responder
//   DRAM-side receiver for the DDR3 command bus during power-up init. Decodes
//   each sampled command and checks it against the JEDEC init order:
//   CKE up, tXPR, MR2, MR3, MR1, MR0, tMOD, ZQCL, tZQinit. Captures mode
//   register payloads, raises init_done or a sticky first-error code.
// Ports
//   clk, rst        : sample clock (rising edge), async active-high reset
//   bus (slave)     : cke/cs_n/ras_n/cas_n/we_n/ba/addr from the PHY
//   cmd_valid       : 1-cycle pulse, a non-NOP/non-DES command was decoded
//   cmd_code[2:0]   : 0 MRS,1 REF,2 PRE,3 ACT,4 WR,5 RD,6 ZQ,7 NOP/DES
//   mr0..mr3        : last captured MRS payloads
//   init_done       : full sequence + tZQinit complete, holds until rst
//   init_err        : sticky error flag
//   err_code[2:0]   : first error cause (1 timing, 2 order, 3 cke drop,
//                     4 illegal command, 5 MR content)
// Build option
//   INIT_MR_CHECK_EN : enables content checks of MR0 (BL8, CL!=0) and
//                      MR1 (DLL enabled) payloads, reported as error 5.
module ddr3_init_cmd_responder #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14,
    parameter int T_XPR     = 170,
    parameter int T_MRD     = 4,
    parameter int T_MOD     = 12,
    parameter int T_ZQINIT  = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    ddr3_init_cmd_responder_if.slave  bus,
    output logic                      cmd_valid,
    output logic [2:0]                cmd_code,
    output logic [ADDR_BITS-1:0]      mr0,
    output logic [ADDR_BITS-1:0]      mr1,
    output logic [ADDR_BITS-1:0]      mr2,
    output logic [ADDR_BITS-1:0]      mr3,
    output logic                      init_done,
    output logic                      init_err,
    output logic [2:0]                err_code
);
    localparam int T_MAX = (T_XPR > T_ZQINIT) ? T_XPR : T_ZQINIT;
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] XPR_M1 = CW'(T_XPR - 1);
    localparam logic [CW-1:0] MRD_M1 = CW'(T_MRD - 1);
    localparam logic [CW-1:0] MOD_M1 = CW'(T_MOD - 1);
    localparam logic [CW-1:0] ZQ_M1  = CW'(T_ZQINIT - 1);

    // WAIT_XPR doubles as the "expect MR2" state.
    localparam logic [3:0] S_WAIT_CKE = 4'd0;
    localparam logic [3:0] S_WAIT_XPR = 4'd1;
    localparam logic [3:0] S_MR3      = 4'd2;
    localparam logic [3:0] S_MR1      = 4'd3;
    localparam logic [3:0] S_MR0      = 4'd4;
    localparam logic [3:0] S_WAIT_MOD = 4'd5;
    localparam logic [3:0] S_WAIT_ZQ  = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ERR      = 4'd8;

    logic [3:0]    state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    dec;
    logic          is_cmd, is_mrs, is_zq, is_pre;
    logic [1:0]    mr_idx, exp_idx;
    logic [CW-1:0] min_gap;
    logic          e1, e2, e4, e5;
    logic          cap;
    logic [2:0]    code;
    logic          unused_ba;

    assign unused_ba = ^bus.ba;

    // Command decode; NOP and DES both collapse to 7.
    always_comb begin
        dec    = bus.cs_n ? 3'd7 : {bus.ras_n, bus.cas_n, bus.we_n};
        is_cmd = (dec != 3'd7);
        is_mrs = (dec == 3'd0);
        is_pre = (dec == 3'd2);
        is_zq  = (dec == 3'd6);
        mr_idx = bus.ba[1:0];
    end

    always_comb begin
        nxt     = state;
        cap     = 1'b0;
        e1      = 1'b0;
        e2      = 1'b0;
        e4      = 1'b0;
        e5      = 1'b0;
        exp_idx = 2'd2;
        min_gap = MRD_M1;
        code    = 3'd0;

        case (state)
            S_WAIT_CKE: begin
                if (is_cmd)       e4  = 1'b1;
                else if (bus.cke) nxt = S_WAIT_XPR;
            end
            S_WAIT_XPR, S_MR3, S_MR1, S_MR0: begin
                case (state)
                    S_WAIT_XPR: begin exp_idx = 2'd2; min_gap = XPR_M1; end
                    S_MR3:      exp_idx = 2'd3;
                    S_MR1:      exp_idx = 2'd1;
                    default:    exp_idx = 2'd0;
                endcase
                if (is_mrs) begin
                    if (cnt < min_gap)      e1 = 1'b1;
                    if (mr_idx != exp_idx)  e2 = 1'b1;
`ifdef INIT_MR_CHECK_EN
                    else if (state == S_MR0)
                        e5 = (bus.addr[1:0] != 2'b00) ||
                             ({bus.addr[6:4], bus.addr[2]} == 4'd0);
                    else if (state == S_MR1)
                        e5 = bus.addr[0];
`endif
                    cap = 1'b1;
                    case (state)
                        S_WAIT_XPR: nxt = S_MR3;
                        S_MR3:      nxt = S_MR1;
                        S_MR1:      nxt = S_MR0;
                        default:    nxt = S_WAIT_MOD;
                    endcase
                end else if (is_zq) begin
                    e2 = 1'b1;
                end else if (is_cmd && !(is_pre && state == S_WAIT_XPR)) begin
                    // PREA ahead of MR2 is legal
                    e4 = 1'b1;
                end
            end
            S_WAIT_MOD: begin
                if (is_zq) begin
                    if (!bus.addr[10])  e2 = 1'b1;
                    if (cnt < MOD_M1)   e1 = 1'b1;
                    nxt = S_WAIT_ZQ;
                end else if (is_mrs) begin
                    e2 = 1'b1;
                end else if (is_cmd) begin
                    e4 = 1'b1;
                end
            end
            S_WAIT_ZQ: begin
                if (is_cmd)             e1  = 1'b1;
                else if (cnt == ZQ_M1)  nxt = S_DONE;
            end
            S_DONE: begin
                cap = is_mrs;
            end
            default: ;
        endcase

        // cke drop outranks everything; otherwise the lowest cause wins.
        if (state != S_WAIT_CKE && state != S_ERR && !bus.cke) code = 3'd3;
        else if (e1) code = 3'd1;
        else if (e2) code = 3'd2;
        else if (e4) code = 3'd4;
        else if (e5) code = 3'd5;

        if (code != 3'd0) begin
            nxt = S_ERR;
            cap = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_WAIT_CKE;
            cnt       <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd7;
            mr0       <= '0;
            mr1       <= '0;
            mr2       <= '0;
            mr3       <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            state     <= nxt;
            cmd_valid <= is_cmd;
            cmd_code  <= dec;
            init_done <= (nxt == S_DONE);

            if (nxt != state)  cnt <= '0;
            else if (cnt != '1) cnt <= cnt + 1'b1;

            // code is only ever non-zero outside ERR, so this latches once
            if (code != 3'd0) begin
                init_err <= 1'b1;
                err_code <= code;
            end

            if (cap) begin
                case (mr_idx)
                    2'd0:    mr0 <= bus.addr;
                    2'd1:    mr1 <= bus.addr;
                    2'd2:    mr2 <= bus.addr;
                    default: mr3 <= bus.addr;
                endcase
            end
        end
    end
endmodule
